adc_spi_scan_ctrl: RTL and testbench

- Parametrised multi-channel SPI sequencer for the ADC128S022-class 8-channel, 12-bit ADC on the ldr_external_interface pins. Supersedes the single-channel sensor read path.
- Scans a programmable channel mask and averages 2^AVG_LOG2 conversions per channel.
- Emits one 12-bit averaged result per channel, tagged with its channel number, to the PID/control logic.

---
 rtl/adc_spi_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_adc_spi_scan_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_scan_ctrl.sv
// rtl/adc_spi_scan_ctrl.sv - multi-channel averaging SPI scan sequencer for an ADC128S022-class ADC
module adc_spi_scan_ctrl #(
    parameter int NUM_CH   = 8,
    parameter int CLK_DIV  = 2,
    parameter int AVG_LOG2 = 0
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic        continuous,
    input  logic [7:0]  ch_mask,
    output logic        sclk,
    output logic        cs_n,
    output logic        din,
    input  logic        dout,
    output logic        busy,
    output logic        result_valid,
    output logic [2:0]  result_ch,
    output logic [11:0] result_data,
    output logic        scan_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CS_SETUP = 3'd1;
    localparam logic [2:0] S_SCLK_LO  = 3'd2;
    localparam logic [2:0] S_SCLK_HI  = 3'd3;
    localparam logic [2:0] S_CS_GAP   = 3'd4;

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int REP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = 12 + AVG_LOG2;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]       CH_VALID = 8'((9'd1 << NUM_CH) - 9'd1);

    logic [2:0]       state;
    logic [CNT_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic             pending;
    logic [7:0]       mask_l;
    logic [11:0]      shift;
    logic [ACC_W-1:0] acc;

    // Address of the frame on the wire and what the sequencer knows about it.
    logic [2:0]       cur_ch;
    logic [REP_W-1:0] cur_rep;
    logic             cur_trail;
    // The ADC returns data one frame late, so the data arriving now belongs
    // to the previous frame's address.
    logic [2:0]       prev_ch;
    logic             prev_valid;
    logic             prev_last_rep;
    logic             prev_last_ch;
    logic             scan_end;

    logic [7:0]       mask_in;
    logic [3:0]       first_in;
    logic [3:0]       first_l;
    logic [3:0]       nxt;
    logic [ACC_W-1:0] acc_sum;
    logic             div_done;
    logic             cur_last_rep;

    // Lowest set bit of m at or above 'from'; bit 3 set means none found.
    function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b1000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) begin
                r = {1'b0, 3'(i)};
            end
        end
        return r;
    endfunction

    // Frame bits 2..4 carry the channel address MSB first; all others are 0.
    function automatic logic addr_bit(input logic [3:0] idx, input logic [2:0] ch);
        case (idx)
            4'd2:    return ch[2];
            4'd3:    return ch[1];
            4'd4:    return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        mask_in      = ch_mask & CH_VALID;
        first_in     = find_from(mask_in, 4'd0);
        first_l      = find_from(mask_l, 4'd0);
        nxt          = find_from(mask_l, {1'b0, cur_ch} + 4'd1);
        acc_sum      = acc + ACC_W'(shift);
        div_done     = (div_cnt == DIV_LAST);
        cur_last_rep = (cur_rep == REP_LAST);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            pending       <= 1'b0;
            mask_l        <= '0;
            shift         <= '0;
            acc           <= '0;
            cur_ch        <= '0;
            cur_rep       <= '0;
            cur_trail     <= 1'b0;
            prev_ch       <= '0;
            prev_valid    <= 1'b0;
            prev_last_rep <= 1'b0;
            prev_last_ch  <= 1'b0;
            scan_end      <= 1'b0;
            sclk          <= 1'b1;
            cs_n          <= 1'b1;
            din           <= 1'b0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result_ch     <= '0;
            result_data   <= '0;
            scan_done     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            scan_done    <= 1'b0;
            if (state != S_IDLE) begin
                div_cnt <= div_done ? '0 : div_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    // One registered step between sampling start and
                    // asserting cs_n: the mask is latched first, then the
                    // first channel is looked up from the latched copy.
                    if (pending) begin
                        pending    <= 1'b0;
                        state      <= S_CS_SETUP;
                        cs_n       <= 1'b0;
                        busy       <= 1'b1;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        cur_ch     <= first_l[2:0];
                        cur_rep    <= '0;
                        cur_trail  <= 1'b0;
                        prev_valid <= 1'b0;
                        acc        <= '0;
                    end else if (start && !first_in[3]) begin
                        pending <= 1'b1;
                        mask_l  <= mask_in;
                    end
                end

                S_CS_SETUP: begin
                    if (div_done) begin
                        state <= S_SCLK_LO;
                        sclk  <= 1'b0;
                        din   <= addr_bit(4'd0, cur_ch);
                    end
                end

                S_SCLK_LO: begin
                    if (div_done) begin
                        state <= S_SCLK_HI;
                        sclk  <= 1'b1;
                        // Only the last 12 of the 16 bits are conversion data.
                        shift <= {shift[10:0], dout};
                    end
                end

                S_SCLK_HI: begin
                    if (div_done) begin
                        if (bit_cnt == 4'd15) begin
                            state    <= S_CS_GAP;
                            cs_n     <= 1'b1;
                            bit_cnt  <= '0;
                            scan_end <= cur_trail;

                            if (prev_valid) begin
                                if (prev_last_rep) begin
                                    result_valid <= 1'b1;
                                    result_ch    <= prev_ch;
                                    result_data  <= acc_sum[AVG_LOG2 +: 12];
                                    scan_done    <= prev_last_ch;
                                    acc          <= '0;
                                end else begin
                                    acc <= acc_sum;
                                end
                            end

                            prev_valid    <= !cur_trail;
                            prev_ch       <= cur_ch;
                            prev_last_rep <= cur_last_rep;
                            prev_last_ch  <= nxt[3];

                            if (!cur_trail) begin
                                if (!cur_last_rep) begin
                                    cur_rep <= cur_rep + REP_W'(1);
                                end else if (!nxt[3]) begin
                                    cur_ch  <= nxt[2:0];
                                    cur_rep <= '0;
                                end else begin
                                    // Extra frame addressing channel 0 only
                                    // to clock out the last conversion.
                                    cur_trail <= 1'b1;
                                    cur_ch    <= '0;
                                    cur_rep   <= '0;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            state   <= S_SCLK_LO;
                            sclk    <= 1'b0;
                            din     <= addr_bit(bit_cnt + 4'd1, cur_ch);
                        end
                    end
                end

                S_CS_GAP: begin
                    if (div_done) begin
                        if (!scan_end) begin
                            state <= S_CS_SETUP;
                            cs_n  <= 1'b0;
                        end else if (continuous && !first_in[3]) begin
                            mask_l     <= mask_in;
                            state      <= S_CS_SETUP;
                            cs_n       <= 1'b0;
                            cur_ch     <= first_in[2:0];
                            cur_rep    <= '0;
                            cur_trail  <= 1'b0;
                            prev_valid <= 1'b0;
                            acc        <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_scan_ctrl.sv
// tb/tb_adc_spi_scan_ctrl.sv - randomized scoreboard bench for adc_spi_scan_ctrl
module tb_adc_spi_scan_ctrl;

    localparam int NUM_CH   = 8;
    localparam int CLK_DIV  = 2;
    localparam int AVG_LOG2 = 2;
    localparam int NREP     = 1 << AVG_LOG2;
    localparam int BUSY_MAX = 40 * 34 * CLK_DIV + 200;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        start;
    logic        continuous;
    logic [7:0]  ch_mask;
    logic        sclk;
    logic        cs_n;
    logic        din;
    logic        dout;
    logic        busy;
    logic        result_valid;
    logic [2:0]  result_ch;
    logic [11:0] result_data;
    logic        scan_done;

    adc_spi_scan_ctrl #(
        .NUM_CH  (NUM_CH),
        .CLK_DIV (CLK_DIV),
        .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .start       (start),
        .continuous  (continuous),
        .ch_mask     (ch_mask),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .din         (din),
        .dout        (dout),
        .busy        (busy),
        .result_valid(result_valid),
        .result_ch   (result_ch),
        .result_data (result_data),
        .scan_done   (scan_done)
    );

    always #5 clk_clk = ~clk_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_clk) cyc++;

    // ADC model: 4 leading zero bits then 12 data bits, changed on falling sclk.
    int         fbit;
    int         fall_cyc;
    int         rise_cyc = -100;
    int         gap_ref  = -1;
    logic [11:0] conv_val;
    logic [2:0]  addr_cap;
    bit          din_bad;
    int frame_addr_q[$];
    int frame_val_q[$];
    int dir_q[$];

    always @(negedge cs_n) begin
        if (!reset_reset) begin
            if (gap_ref >= 0) check("frame_gap", cyc - gap_ref, CLK_DIV);
            fall_cyc = cyc;
            fbit     = 0;
            addr_cap = 3'd0;
            din_bad  = 1'b0;
            dout     = 1'b0;
            if (dir_q.size() > 0) conv_val = 12'(dir_q.pop_front());
            else                  conv_val = 12'($urandom);
        end
    end

    always @(negedge sclk) begin
        if (!cs_n && !reset_reset) begin
            if (fbit < 16) dout = (fbit < 4) ? 1'b0 : conv_val[15 - fbit];
            fbit++;
        end
    end

    always @(posedge sclk) begin
        if (!cs_n && !reset_reset) begin
            if (fbit >= 3 && fbit <= 5) addr_cap[5 - fbit] = din;
            else if (din) din_bad = 1'b1;
        end
    end

    always @(posedge cs_n) begin
        if (!reset_reset) begin
            check("cs_low_len", cyc - fall_cyc, 33 * CLK_DIV);
            check("sclk_periods", fbit, 16);
            check("din_idle_bits", int'(din_bad), 0);
            frame_addr_q.push_back(int'(addr_cap));
            frame_val_q.push_back(int'(conv_val));
            rise_cyc = cyc;
            gap_ref  = cyc;
        end
    end

    int res_ch_q[$];
    int res_data_q[$];
    int res_done_q[$];
    int done_cnt = 0;

    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (result_valid) begin
                res_ch_q.push_back(int'(result_ch));
                res_data_q.push_back(int'(result_data));
                res_done_q.push_back(int'(scan_done));
                check("rv_first_gap_cycle", cyc - rise_cyc, 0);
            end
            if (scan_done) begin
                done_cnt++;
                check("done_with_valid", int'(result_valid), 1);
            end
        end
    end

    // Reference: addresses are enabled channels ascending, each NREP times,
    // then channel 0; data of frame j+1 is the conversion for frame j.
    int exp_addr_q[$];
    int exp_ch_q[$];
    int exp_data_q[$];
    int exp_done_q[$];

    task automatic ref_scan(input logic [7:0] m, input int base, output int used);
        int n;
        int sum;
        n = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m[ch]) begin
                sum = 0;
                for (int r = 0; r < NREP; r++) begin
                    exp_addr_q.push_back(ch);
                    if (base + n + 1 < frame_val_q.size()) sum += frame_val_q[base + n + 1];
                    n++;
                end
                exp_ch_q.push_back(ch);
                exp_data_q.push_back(sum / NREP);
                exp_done_q.push_back(0);
            end
        end
        exp_addr_q.push_back(0);
        n++;
        if (exp_done_q.size() > 0) exp_done_q[exp_done_q.size() - 1] = 1;
        used = n;
    endtask

    task automatic clear_logs();
        frame_addr_q.delete();
        frame_val_q.delete();
        res_ch_q.delete();
        res_data_q.delete();
        res_done_q.delete();
        exp_addr_q.delete();
        exp_ch_q.delete();
        exp_data_q.delete();
        exp_done_q.delete();
        done_cnt = 0;
        gap_ref  = -1;
    endtask

    task automatic compare_run();
        int n;
        check("n_frames", frame_addr_q.size(), exp_addr_q.size());
        n = (frame_addr_q.size() < exp_addr_q.size()) ? frame_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) check("frame_addr", frame_addr_q[i], exp_addr_q[i]);
        check("n_results", res_ch_q.size(), exp_ch_q.size());
        n = (res_ch_q.size() < exp_ch_q.size()) ? res_ch_q.size() : exp_ch_q.size();
        for (int i = 0; i < n; i++) begin
            check("result_ch", res_ch_q[i], exp_ch_q[i]);
            check("result_data", res_data_q[i], exp_data_q[i]);
            check("scan_done_flag", res_done_q[i], exp_done_q[i]);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < maxc) begin
            @(negedge clk_clk);
            n++;
        end
        check(tag, int'(busy === lvl), 1);
    endtask

    task automatic run_scan(input logic [7:0] m, input bit lat, input bit poke);
        int used;
        clear_logs();
        @(negedge clk_clk);
        ch_mask = m;
        start   = 1'b1;
        if (lat) begin
            @(posedge clk_clk);
            #1;
            check("lat_busy_n", int'(busy), 0);
            check("lat_cs_n_n", int'(cs_n), 1);
            @(posedge clk_clk);
            #1;
            check("lat_busy_n1", int'(busy), 1);
            check("lat_cs_n_n1", int'(cs_n), 0);
            @(negedge clk_clk);
        end else begin
            wait_busy(1'b1, 10, "busy_rise");
        end
        start = 1'b0;
        if (poke) begin
            repeat (100) @(negedge clk_clk);
            start   = 1'b1;
            ch_mask = 8'($urandom);
            @(negedge clk_clk);
            start = 1'b0;
        end
        wait_busy(1'b0, BUSY_MAX, "busy_fall");
        check("busy_drop_delay", cyc - rise_cyc, CLK_DIV);
        ref_scan(m, 0, used);
        compare_run();
        repeat (10) @(negedge clk_clk);
        check("idle_after_scan", int'(busy), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int lowc;
        int n;
        int base;
        int used;
        logic [7:0] m;

        reset_reset = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        ch_mask     = 8'h00;
        dout        = 1'b0;
        repeat (3) @(negedge clk_clk);
        check("rst_sclk", int'(sclk), 1);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_din", int'(din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_scan_done", int'(scan_done), 0);
        check("rst_result_ch", int'(result_ch), 0);
        check("rst_result_data", int'(result_data), 0);
        reset_reset = 1'b0;
        repeat (2) @(negedge clk_clk);

        // Single channel, constant conversion value, with latency check.
        clear_logs();
        repeat (5) dir_q.push_back(12'hABC);
        run_scan(8'h01, 1'b1, 1'b0);
        check("t1_data", (res_data_q.size() > 0) ? res_data_q[0] : -1, 12'hABC);
        check("t1_frames", frame_addr_q.size(), 1 * NREP + 1);

        // Averaging: 10,11,12,14 -> 47 >> 2 = 11; leading frame data discarded.
        dir_q.delete();
        dir_q.push_back(12'hFFF);
        dir_q.push_back(10);
        dir_q.push_back(11);
        dir_q.push_back(12);
        dir_q.push_back(14);
        dir_q.push_back(12'h000);
        run_scan(8'h02, 1'b0, 1'b0);
        check("avg_data", (res_data_q.size() > 0) ? res_data_q[0] : -1, 11);
        check("avg_ch", (res_ch_q.size() > 0) ? res_ch_q[0] : -1, 1);

        // Sparse mask with a start pulse and mask change mid-scan.
        dir_q.delete();
        run_scan(8'hA5, 1'b0, 1'b1);

        // Empty mask never starts a scan.
        @(negedge clk_clk);
        ch_mask = 8'h00;
        start   = 1'b1;
        lowc    = 0;
        repeat (20) begin
            @(negedge clk_clk);
            if (busy || !cs_n) lowc++;
        end
        start = 1'b0;
        check("mask0_no_activity", lowc, 0);

        // Continuous mode: three back-to-back scans, busy never drops.
        clear_logs();
        @(negedge clk_clk);
        continuous = 1'b1;
        ch_mask    = 8'h03;
        start      = 1'b1;
        wait_busy(1'b1, 10, "cont_busy_rise");
        start = 1'b0;
        lowc  = 0;
        n     = 0;
        while (done_cnt < 3 && n < 3 * (2 * NREP + 1) * 34 * CLK_DIV + 500) begin
            @(negedge clk_clk);
            n++;
            if (!busy) lowc++;
        end
        continuous = 1'b0;
        check("cont_scans", done_cnt, 3);
        check("cont_busy_held", lowc, 0);
        wait_busy(1'b0, BUSY_MAX, "cont_busy_fall");
        base = 0;
        repeat (3) begin
            ref_scan(8'h03, base, used);
            base += used;
        end
        compare_run();
        check("cont_results", res_ch_q.size(), 6);

        // Reset during the high phase of sclk in frame 2.
        clear_logs();
        @(negedge clk_clk);
        ch_mask = 8'h81;
        start   = 1'b1;
        wait_busy(1'b1, 10, "rst_busy_rise");
        start = 1'b0;
        n = 0;
        while (frame_addr_q.size() < 1 && n < 200) begin
            @(negedge clk_clk);
            n++;
        end
        while (sclk !== 1'b0 && n < 300) begin
            @(negedge clk_clk);
            n++;
        end
        while (sclk !== 1'b1 && n < 400) begin
            @(negedge clk_clk);
            n++;
        end
        check("rst_reached_frame2_hi", int'(sclk === 1'b1 && cs_n === 1'b0), 1);
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        check("midrst_cs_n", int'(cs_n), 1);
        check("midrst_sclk", int'(sclk), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_result_valid", int'(result_valid), 0);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        check("midrst_no_result", res_ch_q.size(), 0);
        repeat (3) @(negedge clk_clk);
        run_scan(8'h81, 1'b0, 1'b0);

        // Random masks.
        repeat (4) begin
            m = 8'($urandom);
            if (m == 8'h00) m = 8'h10;
            run_scan(m, 1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
